// File: rtl/atm_keypad_frontend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : atm_keypad_frontend                                        |
// | Description : Keypad front end for an ATM core. Assembles account, PIN,  |
// |               menu option, amount and destination fields from key       |
// |               strobes, issues a ready/valid request, captures the       |
// |               one-cycle response and performs inactivity logout.        |
// | Revision    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, reset            system clock, synchronous active-high reset      |
// |   key_valid, key_code   key strobe; 0-9 digit, A ENTER, B CLEAR,          |
// |                         C CANCEL, D-F ignored                            |
// |   req_valid/req_ready   request handshake to the ATM core                |
// |   req_accNumber, req_pin, req_menuOption, req_amount,                    |
// |   req_destinationAcc    request fields, stable while req_valid is high   |
// |   rsp_valid/rsp_error/rsp_balance  one-cycle response from the core      |
// |   exit                  one-cycle logout pulse                           |
// |   key_err               one-cycle pulse for a rejected key               |
// |   disp_state            current state encoding                           |
// |   last_error/last_balance  copy of the most recent response              |
// +--------------------------------------------------------------------------+
module atm_keypad_frontend #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [11:0] req_accNumber,
  output logic [3:0]  req_pin,
  output logic [2:0]  req_menuOption,
  output logic [10:0] req_amount,
  output logic [11:0] req_destinationAcc,
  input  logic        rsp_valid,
  input  logic        rsp_error,
  input  logic [10:0] rsp_balance,
  output logic        exit,
  output logic        key_err,
  output logic [2:0]  disp_state,
  output logic        last_error,
  output logic [10:0] last_balance
);

  typedef enum logic [2:0] {
    ENTER_ACC = 3'd0,
    ENTER_PIN = 3'd1,
    SELECT    = 3'd2,
    AMOUNT    = 3'd3,
    DEST      = 3'd4,
    SEND      = 3'd5,
    WAIT_RSP  = 3'd6
  } state_t;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  // The idle counter only needs to reach TIMEOUT_CYCLES-1; the timeout fires
  // on the idle cycle that would take it to TIMEOUT_CYCLES.
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [2:0]        digit_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic [11:0] field_val;
  logic [11:0] field_limit;
  logic [16:0] field_next;
  logic        digit_fits;
  logic        counting;
  logic        key_state;
  logic        timeout_hit;
  logic        do_cancel;

  // Value and ceiling of the field being typed in the current entry state.
  always_comb begin
    field_val   = '0;
    field_limit = '0;
    case (state)
      ENTER_ACC: begin field_val = req_accNumber;             field_limit = 12'd4095; end
      ENTER_PIN: begin field_val = {8'd0, req_pin};           field_limit = 12'd9;    end
      AMOUNT:    begin field_val = {1'b0, req_amount};        field_limit = 12'd2047; end
      DEST:      begin field_val = req_destinationAcc;        field_limit = 12'd4095; end
      default:   begin field_val = '0;                        field_limit = '0;       end
    endcase
  end

  // Wide enough for 4095*10+9 so the limit comparison never wraps.
  assign field_next = ({5'd0, field_val} * 17'd10) + {13'd0, key_code};
  assign digit_fits = (digit_cnt < 3'd4) && (field_next <= {5'd0, field_limit});

  assign counting  = (state == ENTER_PIN) || (state == SELECT) ||
                     (state == AMOUNT)    || (state == DEST);
  assign key_state = (state != SEND) && (state != WAIT_RSP);

  // A key in the same cycle resets the counter, so a coincident CANCEL and
  // timeout collapse into one cancel and one exit pulse.
  assign timeout_hit = counting && !key_valid && (idle_cnt == IDLE_LAST);
  assign do_cancel   = key_state &&
                       (timeout_hit || (key_valid && (key_code == KEY_CANCEL)));

  assign req_valid  = (state == SEND);
  assign disp_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ENTER_ACC;
      digit_cnt          <= '0;
      idle_cnt           <= '0;
      req_accNumber      <= '0;
      req_pin            <= '0;
      req_menuOption     <= '0;
      req_amount         <= '0;
      req_destinationAcc <= '0;
      exit               <= 1'b0;
      key_err            <= 1'b0;
      last_error         <= 1'b0;
      last_balance       <= '0;
    end else begin
      exit    <= 1'b0;
      key_err <= 1'b0;

      // Held at zero outside the counting states, which also covers the
      // clear-on-state-change rule for every transition into them.
      if (!counting || key_valid || timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end

      if (do_cancel) begin
        exit               <= 1'b1;
        state              <= ENTER_ACC;
        digit_cnt          <= '0;
        req_accNumber      <= '0;
        req_pin            <= '0;
        req_menuOption     <= '0;
        req_amount         <= '0;
        req_destinationAcc <= '0;
      end else begin
        case (state)
          SEND: begin
            if (req_ready) state <= WAIT_RSP;
          end

          WAIT_RSP: begin
            if (rsp_valid) begin
              last_error   <= rsp_error;
              last_balance <= rsp_balance;
              digit_cnt    <= '0;
              if ((req_menuOption == 3'd0) && rsp_error) begin
                state         <= ENTER_ACC;
                req_accNumber <= '0;
                req_pin       <= '0;
              end else begin
                state              <= SELECT;
                req_amount         <= '0;
                req_destinationAcc <= '0;
              end
            end
          end

          SELECT: begin
            if (key_valid) begin
              if ((key_code >= 4'd3) && (key_code <= 4'd6)) begin
                req_menuOption <= key_code[2:0];
                digit_cnt      <= '0;
                if (key_code == 4'd3)      state <= SEND;
                else if (key_code == 4'd6) state <= DEST;
                else                       state <= AMOUNT;
              end else if (key_code <= KEY_CLEAR) begin
                key_err <= 1'b1;
              end
            end
          end

          ENTER_ACC, ENTER_PIN, AMOUNT, DEST: begin
            if (key_valid) begin
              if (key_code <= 4'd9) begin
                if (digit_fits) begin
                  digit_cnt <= digit_cnt + 3'd1;
                  case (state)
                    ENTER_ACC: req_accNumber      <= field_next[11:0];
                    ENTER_PIN: req_pin            <= field_next[3:0];
                    AMOUNT:    req_amount         <= field_next[10:0];
                    default:   req_destinationAcc <= field_next[11:0];
                  endcase
                end else begin
                  key_err <= 1'b1;
                end
              end else if (key_code == KEY_ENTER) begin
                if (digit_cnt == 3'd0) begin
                  key_err <= 1'b1;
                end else begin
                  digit_cnt <= '0;
                  case (state)
                    ENTER_ACC: state <= ENTER_PIN;
                    ENTER_PIN: begin
                      state          <= SEND;
                      req_menuOption <= 3'd0;
                    end
                    DEST:      state <= AMOUNT;
                    default:   state <= SEND;
                  endcase
                end
              end else if (key_code == KEY_CLEAR) begin
                digit_cnt <= '0;
                case (state)
                  ENTER_ACC: req_accNumber      <= '0;
                  ENTER_PIN: req_pin            <= '0;
                  AMOUNT:    req_amount         <= '0;
                  default:   req_destinationAcc <= '0;
                endcase
              end
            end
          end

          default: state <= ENTER_ACC;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_atm_keypad_frontend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_atm_keypad_frontend                                     |
// | Description : Self-checking bench for atm_keypad_frontend. A behavioural |
// |               model follows the keypad rules cycle by cycle and every   |
// |               output is compared against it each cycle; directed key    |
// |               sequences add literal expectations at key points.         |
// | Revision    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------------+
module tb_atm_keypad_frontend;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic        rsp_error = 1'b0;
  logic [10:0] rsp_balance = 11'd0;
  logic        req_valid;
  logic [11:0] req_accNumber;
  logic [3:0]  req_pin;
  logic [2:0]  req_menuOption;
  logic [10:0] req_amount;
  logic [11:0] req_destinationAcc;
  logic        exit;
  logic        key_err;
  logic [2:0]  disp_state;
  logic        last_error;
  logic [10:0] last_balance;

  atm_keypad_frontend #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_code(key_code),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_accNumber(req_accNumber), .req_pin(req_pin),
    .req_menuOption(req_menuOption), .req_amount(req_amount),
    .req_destinationAcc(req_destinationAcc),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_balance(rsp_balance),
    .exit(exit), .key_err(key_err), .disp_state(disp_state),
    .last_error(last_error), .last_balance(last_balance)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int exit_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States by their display code: 0 acc, 1 pin, 2 select, 3 amount,
  // 4 dest, 5 send, 6 wait response. Fields: 0 acc, 1 pin, 2 amount, 3 dest.
  int m_st, m_nd, m_menu, m_idle, m_lbal;
  int m_fld[4];
  bit m_ex, m_ke, m_lerr;
  int lim[4] = '{4095, 9, 2047, 4095};

  function automatic int fidx(input int s);
    case (s)
      0: return 0;
      1: return 1;
      3: return 2;
      4: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_step(input bit kv, input int kc, input bit rr, input bit rv,
                            input bit re, input int rb, input bit rst);
    int f, v;
    bit tmo;
    m_ex = 1'b0;
    m_ke = 1'b0;
    if (rst) begin
      m_st = 0; m_nd = 0; m_menu = 0; m_idle = 0; m_lerr = 1'b0; m_lbal = 0;
      foreach (m_fld[i]) m_fld[i] = 0;
      return;
    end
    if (m_st == 5) begin
      m_idle = 0;
      if (rr) m_st = 6;
      return;
    end
    if (m_st == 6) begin
      m_idle = 0;
      if (rv) begin
        m_lerr = re;
        m_lbal = rb;
        m_nd   = 0;
        if (m_menu == 0 && re) begin
          m_st = 0; m_fld[0] = 0; m_fld[1] = 0;
        end else begin
          m_st = 2; m_fld[2] = 0; m_fld[3] = 0;
        end
      end
      return;
    end
    // Entry and select states: count idle cycles, logout on the TMO-th one.
    tmo = 1'b0;
    if (m_st != 0 && !kv) begin
      m_idle++;
      if (m_idle == TMO) tmo = 1'b1;
    end else begin
      m_idle = 0;
    end
    if (tmo || (kv && kc == 12)) begin
      m_ex = 1'b1; m_st = 0; m_nd = 0; m_menu = 0; m_idle = 0;
      foreach (m_fld[i]) m_fld[i] = 0;
      return;
    end
    if (!kv) return;
    f = fidx(m_st);
    if (kc <= 9) begin
      if (m_st == 2) begin
        if (kc >= 3 && kc <= 6) begin
          m_menu = kc;
          m_st = (kc == 3) ? 5 : (kc == 6) ? 4 : 3;
        end else m_ke = 1'b1;
      end else begin
        v = m_fld[f] * 10 + kc;
        if (m_nd < 4 && v <= lim[f]) begin
          m_fld[f] = v;
          m_nd++;
        end else m_ke = 1'b1;
      end
    end else if (kc == 10) begin
      if (m_st == 2 || m_nd == 0) m_ke = 1'b1;
      else begin
        m_nd = 0;
        case (m_st)
          0: m_st = 1;
          1: begin m_st = 5; m_menu = 0; end
          4: m_st = 3;
          default: m_st = 5;
        endcase
      end
    end else if (kc == 11) begin
      if (m_st == 2) m_ke = 1'b1;
      else begin
        m_fld[f] = 0;
        m_nd = 0;
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(posedge clk);
    #2;
    if (chk_en) begin
      check("disp_state",   32'(disp_state),         32'(m_st));
      check("req_valid",    32'(req_valid),          32'(m_st == 5));
      check("acc",          32'(req_accNumber),      32'(m_fld[0]));
      check("pin",          32'(req_pin),            32'(m_fld[1]));
      check("amount",       32'(req_amount),         32'(m_fld[2]));
      check("dest",         32'(req_destinationAcc), 32'(m_fld[3]));
      check("menu",         32'(req_menuOption),     32'(m_menu));
      check("exit",         32'(exit),               32'(m_ex));
      check("key_err",      32'(key_err),            32'(m_ke));
      check("last_error",   32'(last_error),         32'(m_lerr));
      check("last_balance", 32'(last_balance),       32'(m_lbal));
    end
  end

  initial forever begin
    @(posedge clk);
    #3;
    if (exit === 1'b1) exit_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit kv = 0, input int kc = 0, input bit rr = 0, input bit rv = 0,
                     input bit re = 0, input int rb = 0, input bit rst = 0);
    @(negedge clk);
    reset       = rst;
    key_valid   = kv;
    key_code    = 4'(kc);
    req_ready   = rr;
    rsp_valid   = rv;
    rsp_error   = re;
    rsp_balance = 11'(rb);
    model_step(kv, kc, rr, rv, re, rb, rst);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic key(input int k);
    cyc(1, k);
    cyc();
  endtask

  task automatic keys(input int ks[$]);
    foreach (ks[i]) key(ks[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic transact(input bit err, input int bal);
    cyc(0, 0, 1);
    cyc(0, 0, 0, 1, err, bal);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int seq[$];

    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("reset_state", 32'(disp_state), 0);
    check("reset_req_valid", 32'(req_valid), 0);
    check("reset_exit", 32'(exit), 0);

    // Login 2749 / PIN 0 with a stalled handshake.
    seq = '{2, 7, 4, 9, 10, 0, 10};
    keys(seq);
    check("login_state", 32'(disp_state), 5);
    check("login_acc", 32'(req_accNumber), 2749);
    check("login_pin", 32'(req_pin), 0);
    check("login_menu", 32'(req_menuOption), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_acc", 32'(req_accNumber), 2749);
      check("stall_valid", 32'(req_valid), 1);
    end
    cyc(0, 0, 1);
    check("accept_state", 32'(disp_state), 6);
    check("accept_valid", 32'(req_valid), 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("login_ok_state", 32'(disp_state), 2);

    // Withdraw 100.
    seq = '{4, 1, 0, 0, 10};
    keys(seq);
    check("wd_menu", 32'(req_menuOption), 4);
    check("wd_amount", 32'(req_amount), 100);
    transact(0, 400);
    check("wd_balance", 32'(last_balance), 400);
    check("wd_error", 32'(last_error), 0);
    check("wd_state", 32'(disp_state), 2);
    check("wd_amount_clr", 32'(req_amount), 0);

    // Rejections in SELECT.
    cyc(1, 7);
    check("sel_rej7", 32'(key_err), 1);
    cyc(1, 11);
    check("sel_rejclr", 32'(key_err), 1);
    cyc();

    // Amount limit, CLEAR, empty ENTER.
    key(4);
    seq = '{2, 0, 4};
    keys(seq);
    cyc(1, 8);
    check("amt_limit_err", 32'(key_err), 1);
    check("amt_limit_val", 32'(req_amount), 204);
    cyc();
    key(11);
    check("amt_clear", 32'(req_amount), 0);
    cyc(1, 10);
    check("amt_empty_enter", 32'(key_err), 1);
    cyc();
    check("amt_state", 32'(disp_state), 3);
    seq = '{7, 10};
    keys(seq);
    transact(0, 300);

    // Transfer 50 to 2175, core reports error (not a login, so back to SELECT).
    seq = '{6, 2, 1, 7, 5, 10, 5, 0, 10};
    keys(seq);
    check("xfer_menu", 32'(req_menuOption), 6);
    check("xfer_dest", 32'(req_destinationAcc), 2175);
    check("xfer_amount", 32'(req_amount), 50);
    transact(1, 7);
    check("xfer_state", 32'(disp_state), 2);
    check("xfer_err", 32'(last_error), 1);
    check("xfer_dest_clr", 32'(req_destinationAcc), 0);

    // Balance request; keys during SEND are ignored.
    key(3);
    cyc(1, 7);
    check("send_key_ign", 32'(key_err), 0);
    cyc(1, 12);
    check("send_cancel_ign", 32'(exit), 0);
    check("send_state", 32'(disp_state), 5);
    transact(0, 1234);

    // Inactivity logout from SELECT.
    exit_cnt = 0;
    idle(15);
    check("tmo_pre_state", 32'(disp_state), 2);
    idle(1);
    check("tmo_exit", 32'(exit), 1);
    check("tmo_state", 32'(disp_state), 0);
    check("tmo_acc", 32'(req_accNumber), 0);
    idle(4);
    check("tmo_exit_count", 32'(exit_cnt), 1);

    // Response outside WAIT_RSP is ignored.
    cyc(0, 0, 0, 1, 1, 55);
    check("stray_rsp_bal", 32'(last_balance), 1234);
    check("stray_rsp_err", 32'(last_error), 0);

    // Account-field boundaries.
    cyc(1, 10);
    check("acc_empty_enter", 32'(key_err), 1);
    seq = '{4, 0, 9};
    keys(seq);
    cyc(1, 6);
    check("acc_over_err", 32'(key_err), 1);
    cyc();
    key(5);
    cyc(1, 1);
    check("acc_5th_err", 32'(key_err), 1);
    check("acc_max", 32'(req_accNumber), 4095);
    cyc();
    cyc(1, 12);
    check("acc_cancel_exit", 32'(exit), 1);
    check("acc_cancel_val", 32'(req_accNumber), 0);
    cyc();

    // Failed login, with a second PIN digit rejected.
    seq = '{3, 10, 1};
    keys(seq);
    cyc(1, 2);
    check("pin_2nd_err", 32'(key_err), 1);
    check("pin_val", 32'(req_pin), 1);
    cyc();
    key(10);
    transact(1, 0);
    check("badlogin_state", 32'(disp_state), 0);
    check("badlogin_acc", 32'(req_accNumber), 0);
    check("badlogin_pin", 32'(req_pin), 0);

    // CANCEL on the very cycle the timeout would fire.
    seq = '{1, 10, 5, 10};
    keys(seq);
    transact(0, 100);
    exit_cnt = 0;
    idle(15);
    cyc(1, 12);
    check("coinc_exit", 32'(exit), 1);
    check("coinc_state", 32'(disp_state), 0);
    idle(5);
    check("coinc_exit_count", 32'(exit_cnt), 1);

    // CANCEL mid destination entry.
    seq = '{1, 10, 5, 10};
    keys(seq);
    transact(0, 100);
    seq = '{6, 1, 2};
    keys(seq);
    check("dest_partial", 32'(req_destinationAcc), 12);
    cyc(1, 12);
    check("dest_cancel_exit", 32'(exit), 1);
    check("dest_cancel_val", 32'(req_destinationAcc), 0);
    check("dest_cancel_menu", 32'(req_menuOption), 0);
    cyc();

    // Reset while waiting for a response; the late response is dropped.
    seq = '{2, 10, 3, 10};
    keys(seq);
    cyc(0, 0, 1);
    check("wait_state", 32'(disp_state), 6);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 999);
    check("rst_wait_state", 32'(disp_state), 0);
    check("rst_wait_bal", 32'(last_balance), 0);
    check("rst_wait_acc", 32'(req_accNumber), 0);
    check("rst_wait_valid", 32'(req_valid), 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
